// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and state encoding for the decode/execute hazard controller.
package pipe_hazard_ctrl_pkg;
  localparam int REGFILE_ADDR   = 3;
  localparam int DATAPATH_WIDTH = 32;
  localparam int INST_WIDTH     = 32;

  localparam int NREGS_DEF        = 2 ** REGFILE_ADDR;
  localparam int PEND_W_DEF       = 2;
  localparam int FLUSH_CYCLES_DEF = 3;
  localparam int STALLCNT_W_DEF   = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef logic [REGFILE_ADDR-1:0] reg_addr_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/writeback/flush request bus and pipeline-control response bus.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic      dec_valid;
  logic      dec_uses_r1;
  reg_addr_t dec_r1;
  logic      dec_uses_r2;
  reg_addr_t dec_r2;
  logic      dec_wregen;
  reg_addr_t dec_wreg;
  logic      wb_valid;
  reg_addr_t wb_wreg;
  logic      flush_req;

  logic      fd_en;
  logic      de_en;
  logic      pipe_clear;
  logic      issue;
  logic      stall;
  logic [STALLCNT_W_DEF-1:0] stall_count;

  modport master (
    output dec_valid, dec_uses_r1, dec_r1, dec_uses_r2, dec_r2,
           dec_wregen, dec_wreg, wb_valid, wb_wreg, flush_req,
    input  fd_en, de_en, pipe_clear, issue, stall, stall_count
  );

  modport slave (
    input  dec_valid, dec_uses_r1, dec_r1, dec_uses_r2, dec_r2,
           dec_wregen, dec_wreg, wb_valid, wb_wreg, flush_req,
    output fd_en, de_en, pipe_clear, issue, stall, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// Per-register count of in-flight writes between decode issue and writeback retire.
module hazard_scoreboard #(
  parameter int NREGS  = 8,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc_en,
  input  logic [AW-1:0] inc_idx,
  input  logic          dec_en,
  input  logic [AW-1:0] dec_idx,
  input  logic [AW-1:0] r1_idx,
  input  logic [AW-1:0] r2_idx,
  input  logic [AW-1:0] w_idx,
  output logic          r1_busy,
  output logic          r2_busy,
  output logic          w_full
);
  logic [NREGS-1:0][PEND_W-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREGS; i++) begin
      logic inc_hit, dec_hit;
      inc_hit = inc_en && (inc_idx == AW'(i));
      dec_hit = dec_en && (dec_idx == AW'(i));
      if (clr)
        pend_d[i] = '0;
      else if (inc_hit && !dec_hit)
        pend_d[i] = pend_q[i] + PEND_W'(1);
      // A retire against an empty counter is a protocol error; hold at zero.
      else if (dec_hit && !inc_hit && pend_q[i] != '0)
        pend_d[i] = pend_q[i] - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign r1_busy = pend_q[r1_idx] != '0;
  assign r2_busy = pend_q[r2_idx] != '0;
  assign w_full  = pend_q[w_idx] == '1;

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    (dec_en && !clr) |-> (pend_q[dec_idx] != '0))
    else $error("hazard_scoreboard: retire of reg %0d with no write in flight", dec_idx);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Drives the fetch/decode and decode/execute register enables, stalls on RAW
// hazards against in-flight writes, and sequences pipeline flushes.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NREGS        = NREGS_DEF,
  parameter int PEND_W       = PEND_W_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int STALLCNT_W   = STALLCNT_W_DEF
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FC_LOAD = FCW'(FLUSH_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [FCW-1:0]          flush_ctr_q, flush_ctr_d;
  logic [STALLCNT_W-1:0]   stall_count_q, stall_count_d;

  logic sb_clr, sb_inc, sb_dec;
  logic r1_busy, r2_busy, w_full, hazard;
  logic fd_en, de_en, pipe_clear, issue, stall;

  hazard_scoreboard #(.NREGS(NREGS), .PEND_W(PEND_W)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .clr     (sb_clr),
    .inc_en  (sb_inc),
    .inc_idx (bus.dec_wreg),
    .dec_en  (sb_dec),
    .dec_idx (bus.wb_wreg),
    .r1_idx  (bus.dec_r1),
    .r2_idx  (bus.dec_r2),
    .w_idx   (bus.dec_wreg),
    .r1_busy (r1_busy),
    .r2_busy (r2_busy),
    .w_full  (w_full)
  );

  // No writeback bypass: a source retiring this cycle still counts as busy.
  assign hazard = bus.dec_valid & ((bus.dec_uses_r1 & r1_busy) |
                                   (bus.dec_uses_r2 & r2_busy) |
                                   (bus.dec_wregen  & w_full));

  always_comb begin
    state_d     = state_q;
    flush_ctr_d = flush_ctr_q;
    fd_en       = 1'b1;
    de_en       = 1'b1;
    pipe_clear  = 1'b0;
    issue       = 1'b0;
    stall       = 1'b0;
    sb_clr      = 1'b0;
    sb_inc      = 1'b0;
    sb_dec      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.flush_req) begin
          fd_en       = 1'b0;
          pipe_clear  = 1'b1;
          sb_clr      = 1'b1;
          state_d     = ST_FLUSH;
          flush_ctr_d = FC_LOAD;
        end else begin
          stall  = hazard;
          issue  = bus.dec_valid & ~hazard;
          fd_en  = ~hazard;
          sb_inc = issue & bus.dec_wregen;
          sb_dec = bus.wb_valid;
        end
      end
      ST_FLUSH: begin
        fd_en      = 1'b0;
        pipe_clear = 1'b1;
        if (bus.flush_req)
          flush_ctr_d = FC_LOAD;
        else if (flush_ctr_q == '0)
          state_d = ST_RUN;
        else
          flush_ctr_d = flush_ctr_q - FCW'(1);
      end
      default: state_d = ST_RUN;
    endcase
    stall_count_d = (stall && stall_count_q != '1) ? stall_count_q + STALLCNT_W'(1)
                                                   : stall_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      flush_ctr_q   <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_ctr_q   <= flush_ctr_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.fd_en       = fd_en;
  assign bus.de_en       = de_en;
  assign bus.pipe_clear  = pipe_clear;
  assign bus.issue       = issue;
  assign bus.stall       = stall;
  assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenario bench for pipe_hazard_ctrl; outputs checked mid-cycle.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic reset;
  int   nchk  = 0;
  int   npass = 0;

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fd_en, de_en, pipe_clear, issue, stall}
  localparam logic [4:0] O_ISSUE = 5'b11010;
  localparam logic [4:0] O_IDLE  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b01001;
  localparam logic [4:0] O_FLUSH = 5'b01100;

  function automatic logic [4:0] outs();
    return {bus.fd_en, bus.de_en, bus.pipe_clear, bus.issue, bus.stall};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid   = 1'b0;
    bus.dec_uses_r1 = 1'b0;
    bus.dec_r1      = '0;
    bus.dec_uses_r2 = 1'b0;
    bus.dec_r2      = '0;
    bus.dec_wregen  = 1'b0;
    bus.dec_wreg    = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_wreg     = '0;
    bus.flush_req   = 1'b0;
  endtask

  task automatic drive_w(input logic [2:0] r);
    idle();
    bus.dec_valid  = 1'b1;
    bus.dec_wregen = 1'b1;
    bus.dec_wreg   = r;
  endtask

  task automatic drive_rd(input logic [2:0] r);
    idle();
    bus.dec_valid   = 1'b1;
    bus.dec_uses_r1 = 1'b1;
    bus.dec_r1      = r;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    #3;
    bus.dec_valid = 1'b1;
    #1;
    nchk++; if (outs() !== O_ISSUE) $display("FAIL rst_outs: got %b exp %b", outs(), O_ISSUE); else npass++;
    nchk++; if (bus.stall_count !== 16'd0) $display("FAIL rst_cnt: got %0d exp 0", bus.stall_count); else npass++;
    bus.dec_valid = 1'b0;
    #1;
    nchk++; if (outs() !== O_IDLE) $display("FAIL rst_idle: got %b exp %b", outs(), O_IDLE); else npass++;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_raw_stall();
    drive_w(3'd3);
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL issue_w3: got %b exp %b", outs(), O_ISSUE); else npass++;
    tick();
    drive_rd(3'd3);
    @(negedge clk);
    nchk++; if (outs() !== O_STALL) $display("FAIL stall_raw: got %b exp %b", outs(), O_STALL); else npass++;
    tick();
    @(negedge clk);
    nchk++; if (bus.stall_count !== 16'd1) $display("FAIL cnt1: got %0d exp 1", bus.stall_count); else npass++;
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_wreg  = 3'd3;
    @(negedge clk);
    nchk++; if (outs() !== O_STALL) $display("FAIL no_bypass: got %b exp %b", outs(), O_STALL); else npass++;
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL issue_after_wb: got %b exp %b", outs(), O_ISSUE); else npass++;
    nchk++; if (bus.stall_count !== 16'd3) $display("FAIL cnt3: got %0d exp 3", bus.stall_count); else npass++;
    tick();
    idle();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      drive_w(3'd5);
      @(negedge clk);
      nchk++; if (outs() !== O_ISSUE) $display("FAIL w5_issue%0d: got %b exp %b", k, outs(), O_ISSUE); else npass++;
      tick();
    end
    drive_w(3'd5);
    @(negedge clk);
    nchk++; if (outs() !== O_STALL) $display("FAIL w5_full: got %b exp %b", outs(), O_STALL); else npass++;
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_wreg  = 3'd5;
    @(negedge clk);
    nchk++; if (outs() !== O_STALL) $display("FAIL full_wb_same: got %b exp %b", outs(), O_STALL); else npass++;
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL issue_after_free: got %b exp %b", outs(), O_ISSUE); else npass++;
    tick();
    @(negedge clk);
    nchk++; if (outs() !== O_STALL) $display("FAIL pend5_still3: got %b exp %b", outs(), O_STALL); else npass++;
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_wreg  = 3'd5;
    tick();
    tick();
    tick();
    drive_rd(3'd5);
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL pend5_drained: got %b exp %b", outs(), O_ISSUE); else npass++;
    nchk++; if (bus.stall_count !== 16'd5) $display("FAIL cnt5: got %0d exp 5", bus.stall_count); else npass++;
    tick();
    idle();
  endtask

  task automatic test_same_cycle();
    drive_w(3'd2);
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL w2_issue: got %b exp %b", outs(), O_ISSUE); else npass++;
    tick();
    drive_w(3'd2);
    bus.wb_valid = 1'b1;
    bus.wb_wreg  = 3'd2;
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL inc_dec_same: got %b exp %b", outs(), O_ISSUE); else npass++;
    tick();
    drive_rd(3'd2);
    @(negedge clk);
    nchk++; if (outs() !== O_STALL) $display("FAIL pend2_still1: got %b exp %b", outs(), O_STALL); else npass++;
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_wreg  = 3'd2;
    tick();
    drive_rd(3'd2);
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL pend2_was1: got %b exp %b", outs(), O_ISSUE); else npass++;
    tick();
    idle();
  endtask

  task automatic test_flush();
    drive_w(3'd1); tick();
    drive_w(3'd1); tick();
    drive_w(3'd6); tick();
    drive_w(3'd4);
    bus.flush_req = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_wreg   = 3'd1;
    @(negedge clk);
    nchk++; if (outs() !== O_FLUSH) $display("FAIL flush_req_cycle: got %b exp %b", outs(), O_FLUSH); else npass++;
    tick();
    drive_rd(3'd1);
    bus.wb_valid = 1'b1;
    bus.wb_wreg  = 3'd6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nchk++; if (outs() !== O_FLUSH) $display("FAIL flush_hold%0d: got %b exp %b", k, outs(), O_FLUSH); else npass++;
      tick();
    end
    bus.wb_valid = 1'b0;
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL post_flush_rd1: got %b exp %b", outs(), O_ISSUE); else npass++;
    tick();
    drive_rd(3'd6);
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL post_flush_rd6: got %b exp %b", outs(), O_ISSUE); else npass++;
    tick();
    drive_rd(3'd4);
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL post_flush_rd4: got %b exp %b", outs(), O_ISSUE); else npass++;
    nchk++; if (bus.stall_count !== 16'd5) $display("FAIL cnt_kept: got %0d exp 5", bus.stall_count); else npass++;
    tick();
    idle();
  endtask

  task automatic test_flush_reload();
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    tick();
    bus.flush_req = 1'b1;
    @(negedge clk);
    nchk++; if (outs() !== O_FLUSH) $display("FAIL reload_cycle: got %b exp %b", outs(), O_FLUSH); else npass++;
    tick();
    bus.flush_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nchk++; if (outs() !== O_FLUSH) $display("FAIL reload_hold%0d: got %b exp %b", k, outs(), O_FLUSH); else npass++;
      tick();
    end
    @(negedge clk);
    nchk++; if (outs() !== O_IDLE) $display("FAIL reload_done: got %b exp %b", outs(), O_IDLE); else npass++;
    tick();
  endtask

  task automatic test_reset_mid_flush();
    drive_w(3'd7); tick();
    idle();
    bus.flush_req = 1'b1; tick();
    bus.flush_req = 1'b0; tick();
    nchk++; if (outs() !== O_FLUSH) $display("FAIL pre_reset_flush: got %b exp %b", outs(), O_FLUSH); else npass++;
    reset = 1'b0;
    #1;
    nchk++; if (outs() !== O_IDLE) $display("FAIL reset_mid_flush: got %b exp %b", outs(), O_IDLE); else npass++;
    nchk++; if (bus.stall_count !== 16'd0) $display("FAIL reset_cnt: got %0d exp 0", bus.stall_count); else npass++;
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    nchk++; if (outs() !== O_IDLE) $display("FAIL run_after_reset: got %b exp %b", outs(), O_IDLE); else npass++;
    tick();
    drive_w(3'd7); tick();
    idle();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    drive_rd(3'd7);
    @(negedge clk);
    nchk++; if (outs() !== O_ISSUE) $display("FAIL reset_clears_pend: got %b exp %b", outs(), O_ISSUE); else npass++;
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_saturate();
    test_same_cycle();
    test_flush();
    test_flush_reload();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
